// File: rtl/imm_pkg.sv
// imm_pkg: shared encodings and helpers for the immediate extender.
//   Ctrl[3:0] selects the form. I/D/B/CBZ are full 4-bit codes. The MOV forms
//   are identified by their 2-bit prefix in Ctrl[3:2], and Ctrl[1:0] is the
//   halfword index hw.
package imm_pkg;

  localparam logic [3:0] CTRL_I    = 4'b0000;
  localparam logic [3:0] CTRL_D    = 4'b0001;
  localparam logic [3:0] CTRL_B    = 4'b0010;
  localparam logic [3:0] CTRL_CBZ  = 4'b0011;
  localparam logic [1:0] CTRL_MOVZ = 2'b01;
  localparam logic [1:0] CTRL_MOVN = 2'b10;
  localparam logic [1:0] CTRL_MOVK = 2'b11;

  // Mask covering the 16-bit field that halfword hw occupies.
  function automatic logic [63:0] hw_mask(input logic [1:0] hw);
    return 64'hFFFF << {hw, 4'b0000};
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: request/response bundle for imm_extend_pipe.
//   Request side:  in_valid/in_ready, Imm26, Ctrl, OldVal, in_tag.
//   Response side: out_valid/out_ready, BusImm, out_tag, out_err.
//   The master modport is the decode/execute side. The slave modport is the extender.
interface imm_extend_pipe_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [25:0]       Imm26;
  logic [3:0]        Ctrl;
  logic [DATA_W-1:0] OldVal;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] BusImm;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, Imm26, Ctrl, OldVal, in_tag, out_ready,
    input  in_ready, out_valid, BusImm, out_tag, out_err
  );

  modport slave (
    input  in_valid, Imm26, Ctrl, OldVal, in_tag, out_ready,
    output in_ready, out_valid, BusImm, out_tag, out_err
  );
endinterface

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational LEGv8 immediate extension.
//   Inputs:  Imm26 (instr[25:0]), Ctrl (mode), OldVal (destination value, MOVK only).
//   Outputs: result (DATA_W-bit immediate), err (MOV hw not representable at DATA_W=32).
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 1
) (
  input  logic [25:0]       Imm26,
  input  logic [3:0]        Ctrl,
  input  logic [DATA_W-1:0] OldVal,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [15:0]       imm16;
  logic [1:0]        hw;
  logic [DATA_W-1:0] br26, br19, placed, mask;
  logic              illegal;

  assign imm16  = Imm26[20:5];
  assign hw     = Ctrl[1:0];
  assign br26   = {{(DATA_W-26){Imm26[25]}}, Imm26};
  assign br19   = {{(DATA_W-19){Imm26[23]}}, Imm26[23:5]};
  assign placed = DATA_W'({48'b0, imm16} << {hw, 4'b0000});
  assign mask   = DATA_W'(hw_mask(hw));

  // At 32 bits only halfwords 0 and 1 exist.
  assign illegal = (DATA_W == 32) && (Ctrl[3:2] != 2'b00) && hw[1];

  always_comb begin
    result = '0;
    err    = 1'b0;
    if (illegal) begin
      err = 1'b1;
    end else if (Ctrl[3:2] == 2'b00) begin
      case (Ctrl)
        CTRL_I:   result = {{(DATA_W-12){1'b0}}, Imm26[21:10]};
        CTRL_D:   result = {{(DATA_W-9){Imm26[20]}}, Imm26[20:12]};
        CTRL_B:   result = (BR_SHIFT != 0) ? (br26 << 2) : br26;
        CTRL_CBZ: result = (BR_SHIFT != 0) ? (br19 << 2) : br19;
        default:  result = '0;
      endcase
    end else begin
      case (Ctrl[3:2])
        CTRL_MOVZ: result = placed;
        CTRL_MOVN: result = ~placed;
        CTRL_MOVK: result = (OldVal & ~mask) | placed;
        default:   result = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with a skid buffer.
//   CLK, Reset (async, active-high).
//   bus (slave): in_valid/in_ready request with Imm26, Ctrl, OldVal, in_tag.
//                out_valid/out_ready response with BusImm, out_tag, out_err.
//   One-cycle latency. Full throughput. in_ready comes from a flop. Up to 2 results held under stall.
module imm_extend_pipe #(
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 5,
  parameter int BR_SHIFT = 1
) (
  input logic              CLK,
  input logic              Reset,
  imm_extend_pipe_if.slave bus
);

  logic [DATA_W-1:0] res;
  logic              res_err;

  imm_extend_core #(.DATA_W(DATA_W), .BR_SHIFT(BR_SHIFT)) u_core (
    .Imm26  (bus.Imm26),
    .Ctrl   (bus.Ctrl),
    .OldVal (bus.OldVal),
    .result (res),
    .err    (res_err)
  );

  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic              out_err_q, out_err_d, skid_err_q, skid_err_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, load_ok;

  assign accept  = bus.in_valid && in_ready_q;
  // The output register is free if it is empty or drains this cycle.
  assign load_ok = !out_valid_q || bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    // in_ready is low while the skid is full, so accept and skid_valid_q are never both set.
    if (skid_valid_q) begin
      if (load_ok) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (load_ok) begin
        out_valid_d = 1'b1;
        out_data_d  = res;
        out_tag_d   = bus.in_tag;
        out_err_d   = res_err;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = res;
        skid_tag_d   = bus.in_tag;
        skid_err_d   = res_err;
      end
    end else if (load_ok) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.BusImm    = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;
  int   del64 = 0;
  int   del32 = 0;
  exp_t q64[$];
  exp_t q32[$];

  always #5 CLK = ~CLK;

  imm_extend_pipe_if #(.DATA_W(64), .TAG_W(5)) if64 ();
  imm_extend_pipe_if #(.DATA_W(32), .TAG_W(5)) if32 ();

  imm_extend_pipe #(.DATA_W(64), .TAG_W(5), .BR_SHIFT(1)) dut64 (
    .CLK(CLK), .Reset(Reset), .bus(if64.slave));
  imm_extend_pipe #(.DATA_W(32), .TAG_W(5), .BR_SHIFT(1)) dut32 (
    .CLK(CLK), .Reset(Reset), .bus(if32.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare every delivered result against the queue head.
  always @(negedge CLK) begin
    if (!Reset && if64.out_valid && if64.out_ready) begin
      exp_t e;
      del64++;
      checks++;
      if (q64.size() == 0) begin
        failures++;
        $display("FAIL out64_unexpected actual=%h/%0d required=none", if64.BusImm, if64.out_tag);
      end else begin
        e = q64.pop_front();
        if (if64.BusImm !== e.d || if64.out_tag !== e.t || if64.out_err !== e.e) begin
          failures++;
          $display("FAIL out64 actual=%h tag=%0d err=%b required=%h tag=%0d err=%b",
                   if64.BusImm, if64.out_tag, if64.out_err, e.d, e.t, e.e);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!Reset && if32.out_valid && if32.out_ready) begin
      exp_t e;
      del32++;
      checks++;
      if (q32.size() == 0) begin
        failures++;
        $display("FAIL out32_unexpected actual=%h/%0d required=none", if32.BusImm, if32.out_tag);
      end else begin
        e = q32.pop_front();
        if ({32'b0, if32.BusImm} !== e.d || if32.out_tag !== e.t || if32.out_err !== e.e) begin
          failures++;
          $display("FAIL out32 actual=%h tag=%0d err=%b required=%h tag=%0d err=%b",
                   if32.BusImm, if32.out_tag, if32.out_err, e.d, e.t, e.e);
        end
      end
    end
  end

  task automatic send64(input logic [25:0] imm, input logic [3:0] ctrl, input logic [63:0] old,
                        input logic [4:0] tag, input logic [63:0] exp, input logic experr);
    q64.push_back('{d: exp, t: tag, e: experr});
    if64.Imm26 = imm; if64.Ctrl = ctrl; if64.OldVal = old; if64.in_tag = tag;
    if64.in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge CLK);
      if (if64.in_ready === 1'b1) break;
      if (n >= 50) begin
        checks++; failures++;
        $display("FAIL send64_timeout actual=in_ready_low required=accept tag=%0d", tag);
        break;
      end
    end
    @(posedge CLK); #1;
    if64.in_valid = 1'b0;
  endtask

  task automatic send32(input logic [25:0] imm, input logic [3:0] ctrl, input logic [31:0] old,
                        input logic [4:0] tag, input logic [63:0] exp, input logic experr);
    q32.push_back('{d: exp, t: tag, e: experr});
    if32.Imm26 = imm; if32.Ctrl = ctrl; if32.OldVal = old; if32.in_tag = tag;
    if32.in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge CLK);
      if (if32.in_ready === 1'b1) break;
      if (n >= 50) begin
        checks++; failures++;
        $display("FAIL send32_timeout actual=in_ready_low required=accept tag=%0d", tag);
        break;
      end
    end
    @(posedge CLK); #1;
    if32.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cap;
    int d0;
    Reset = 1'b1;
    if64.in_valid = 0; if64.Imm26 = 0; if64.Ctrl = 0; if64.OldVal = 0; if64.in_tag = 0; if64.out_ready = 1;
    if32.in_valid = 0; if32.Imm26 = 0; if32.Ctrl = 0; if32.OldVal = 0; if32.in_tag = 0; if32.out_ready = 1;
    repeat (2) @(posedge CLK); #1;
    chk("rst64_valid", {63'b0, if64.out_valid}, 64'd0);
    chk("rst64_bus", if64.BusImm, 64'd0);
    chk("rst64_tag", {59'b0, if64.out_tag}, 64'd0);
    chk("rst64_err", {63'b0, if64.out_err}, 64'd0);
    chk("rst32_valid", {63'b0, if32.out_valid}, 64'd0);
    chk("rst32_bus", {32'b0, if32.BusImm}, 64'd0);
    chk("rst32_tag", {59'b0, if32.out_tag}, 64'd0);
    chk("rst32_err", {63'b0, if32.out_err}, 64'd0);
    Reset = 1'b0;
    repeat (2) @(posedge CLK); #1;
    chk("in_ready64_after_rst", {63'b0, if64.in_ready}, 64'd1);
    chk("in_ready32_after_rst", {63'b0, if32.in_ready}, 64'd1);

    // First transaction latency: result visible one cycle after accept.
    send64(26'h3FFC00, 4'b0000, 64'd0, 5'd1, 64'h0000_0000_0000_0FFF, 1'b0);
    chk("latency_valid", {63'b0, if64.out_valid}, 64'd1);
    chk("latency_bus", if64.BusImm, 64'h0000_0000_0000_0FFF);

    // Directed 64-bit vectors, streamed back to back.
    send64(26'h0100000, 4'b0001, 64'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FF00, 1'b0); // D -256
    send64(26'h3FFFFFF, 4'b0010, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0); // B -1<<2
    send64(26'h0800000, 4'b0011, 64'd0, 5'd4, 64'hFFFF_FFFF_FFF0_0000, 1'b0); // CBZ
    send64(26'h017DDE0, 4'b1110, 64'h1111_2222_3333_4444, 5'd5, 64'h1111_BEEF_3333_4444, 1'b0); // MOVK hw2
    send64(26'h0000000, 4'b1000, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); // MOVN hw0
    send64(26'h0024680, 4'b0111, 64'd0, 5'd7, 64'h1234_0000_0000_0000, 1'b0); // MOVZ hw3
    send64(26'h0000001, 4'b0010, 64'd0, 5'd8, 64'h0000_0000_0000_0004, 1'b0); // B +1
    send64(26'h0001FE0, 4'b1001, 64'd0, 5'd9, 64'hFFFF_FFFF_FF00_FFFF, 1'b0); // MOVN hw1

    // 32-bit instance: illegal MOVZ hw3 delivered in order between legal ones.
    send32(26'h3FFC00, 4'b0000, 32'd0, 5'd1, 64'h0000_0FFF, 1'b0);
    send32(26'h0024680, 4'b0111, 32'd0, 5'd2, 64'h0, 1'b1);
    send32(26'h017DDE0, 4'b1101, 32'h1111_2222, 5'd3, 64'hBEEF_2222, 1'b0);
    send32(26'h3FFFFFF, 4'b0010, 32'd0, 5'd4, 64'hFFFF_FFFC, 1'b0);
    repeat (3) @(posedge CLK); #1;

    // Full stall: two accepted, third waits, then drain in order.
    if64.out_ready = 1'b0;
    send64(26'h400, 4'b0000, 64'd0, 5'd1, 64'h1, 1'b0);
    send64(26'h800, 4'b0000, 64'd0, 5'd2, 64'h2, 1'b0);
    fork
      send64(26'hC00, 4'b0000, 64'd0, 5'd3, 64'h3, 1'b0);
      begin
        @(negedge CLK);
        chk("stall_in_ready", {63'b0, if64.in_ready}, 64'd0);
        chk("stall_valid", {63'b0, if64.out_valid}, 64'd1);
        chk("stall_tag", {59'b0, if64.out_tag}, 64'd1);
        cap = if64.BusImm;
        repeat (3) @(negedge CLK);
        chk("stall_bus_stable", if64.BusImm, cap);
        chk("stall_tag_stable", {59'b0, if64.out_tag}, 64'd1);
        @(posedge CLK); #1;
        if64.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge CLK); #1;
    chk("stall_q_drained", 64'(q64.size()), 64'd0);

    // Reset with output and skid both full.
    if64.out_ready = 1'b0;
    send64(26'h400, 4'b0000, 64'd0, 5'd7, 64'h1, 1'b0);
    send64(26'h800, 4'b0000, 64'd0, 5'd8, 64'h2, 1'b0);
    Reset = 1'b1;
    #1;
    chk("midrst_valid", {63'b0, if64.out_valid}, 64'd0);
    q64.delete();
    repeat (2) @(posedge CLK); #1;
    Reset = 1'b0;
    if64.out_ready = 1'b1;
    repeat (2) @(posedge CLK); #1;
    d0 = del64;
    send64(26'h1400, 4'b0000, 64'd0, 5'd9, 64'h5, 1'b0);
    repeat (4) @(negedge CLK);
    chk("midrst_one_result", 64'(del64 - d0), 64'd1);

    chk("q64_empty", 64'(q64.size()), 64'd0);
    chk("q32_empty", 64'(q32.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate sign extender in the LEGv8 datapath.
- Produces the DATA_W-bit immediate for I, D, B, CBZ, MOVZ, MOVN and MOVK forms.
  - MOVK merges the immediate into the old destination value.
  - Branch offsets are optionally pre-scaled.
- Sits between decode and execute behind a valid/ready handshake, with a one-cycle registered output and a skid buffer so in_ready is a flop.

Parameters:
- DATA_W, 64, result width; legal values are 32 or 64.
- TAG_W, 5, sideband tag (destination register number) carried alongside the result.
- BR_SHIFT, 1, 1 = B/CBZ results are shifted left by 2 after sign extension; 0 = raw offset.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; registered.
- Imm26  in  26  instruction bits [25:0].
- Ctrl  in  4  extension mode.
- OldVal  in  DATA_W  current destination register value; used only by MOVK.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- BusImm  out  DATA_W  extended immediate.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  illegal mode for this DATA_W.

Behaviour:
- Reset (asynchronous, active-high), at assertion:
  - out_valid=0, BusImm=0, out_tag=0, out_err=0.
  - skid buffer empty; in_ready=1 from the first clock after release.
- Ctrl decode (imm16 = Imm26[20:5]; hw = Ctrl[1:0]):
  - 0000 I: zero-extend Imm26[21:10].
  - 0001 D: sign-extend Imm26[20:12] (9 bits).
  - 0010 B: sign-extend Imm26[25:0], then <<2 if BR_SHIFT.
  - 0011 CBZ: sign-extend Imm26[23:5] (19 bits), then <<2 if BR_SHIFT.
  - 0100–0111 MOVZ: imm16 << 16*hw, other bits 0.
  - 1000–1011 MOVN: bitwise NOT of (imm16 << 16*hw).
  - 1100–1111 MOVK: (OldVal AND NOT(16'hFFFF << 16*hw)) OR (imm16 << 16*hw).
- Width rules:
  - All results are truncated to DATA_W.
  - Sign extension fills up to bit DATA_W-1.
  - The shift by 2 discards bits shifted past DATA_W-1.
- Illegal mode: DATA_W=32 with hw≥2 in any MOV form.
  - Result BusImm=0 with out_err=1.
  - The transaction is still accepted and delivered in order.
- Ctrl 0101–0111 with 0100 base, etc., are all legal at DATA_W=64; there are no reserved codes.
- Handshake:
  - Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
  - Computation is combinational on the accepted inputs; the result is captured into the output register, so latency from accept to out_valid is 1 cycle.
- Output register loading:
  - Loads on accept when it is empty or being drained that cycle (out_ready=1).
  - Otherwise the accepted result goes to the single-entry skid register and in_ready drops next cycle.
  - When the output drains and the skid is full, skid moves to output and in_ready returns to 1 the next cycle.
- Throughput: 1 result per cycle with out_ready held high.
- Full stall: while out_ready=0, the block holds at most 2 results (output + skid). BusImm, out_tag and out_err stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain with skid empty: the output register is replaced by the new result; out_valid stays 1.
- OldVal and in_tag are sampled only on the accept cycle.
- Reset mid-operation discards both the output and skid entries immediately, with no partial delivery.

Decomposition:
- Shared package imm_pkg:
  - Ctrl encodings as localparams: CTRL_I, CTRL_D, CTRL_B, CTRL_CBZ, CTRL_MOVZ, CTRL_MOVN, CTRL_MOVK, where the MOV forms are 2-bit prefixes.
  - Function computing the hw shift mask.
- One combinational sub-module imm_extend_core(Imm26, Ctrl, OldVal → result, err), parametrised by DATA_W and BR_SHIFT.
- The top level holds only the output/skid registers and the handshake.

Test Plan:
- Reset then a single I-type with Imm26[21:10]=12'hFFF, out_ready=1 → one cycle later out_valid=1, BusImm=64'h0000_0000_0000_0FFF, out_err=0.
- B-type with Imm26=26'h3FFFFFF, BR_SHIFT=1 → BusImm=64'hFFFF_FFFF_FFFF_FFFC. CBZ with Imm26[23:5]=19'h40000 → BusImm=64'hFFFF_FFFF_FFF0_0000.
- MOVK hw=2, imm16=16'hBEEF, OldVal=64'h1111_2222_3333_4444 → 64'h1111_BEEF_3333_4444. MOVN hw=0, imm16=0 → 64'hFFFF_FFFF_FFFF_FFFF.
- DATA_W=32, MOVZ hw=3, imm16=16'h1234 → BusImm=32'h0, out_err=1, delivered in order between two legal requests.
- Back-to-back stream of 3 requests with out_ready=0:
  - Two are accepted, then in_ready=0 and the third waits.
  - Raise out_ready → results emerge in order with tags 1,2,3 and no duplication or loss.
- Assert Reset while the output and skid are both full → out_valid=0 immediately; after release the first new request yields exactly one result.
